// File: rtl/led_panel_scan.sv
// led_panel_scan
//   Scan-out reader for the two-half paint framebuffer. Both halves are read in
//   parallel through a shared address and shifted into a 64x64 HUB75 panel
//   (upper rows on R1G1B1, lower rows on R2G2B2). Brightness uses 4-plane
//   binary-code modulation: plane p is displayed for BASE_TICKS<<p cycles.
//   This block only reads the framebuffer.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   enable          run scan; sampled in IDLE and at the end of each display slot
//   rdata0/rdata1   MEM0/MEM1 read data (12'hRGB), valid 1 cycle after rd_addr
//   rd_addr         shared read address {row, col}
//   r1,g1,b1        upper-half pixel bits; r2,g2,b2 lower-half pixel bits
//   pclk            panel shift clock (data sampled on rising edge)
//   lat             panel latch strobe
//   oe_n            panel output enable, active-low
//   row_sel         panel row address A..E
//   frame_start     1-cycle pulse at the start of each frame
//
// Configuration
//   GAMMA_EN  when defined, each 4-bit channel goes through a fixed gamma LUT
//             before plane select (requires COLOR_BITS = 4).
module led_panel_scan #(
    parameter int NUM_COLS   = 64,
    parameter int HALF_ROWS  = 32,
    parameter int COLOR_BITS = 4,
    parameter int BASE_TICKS = 64
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          enable,
    input  logic [3*COLOR_BITS-1:0]                       rdata0,
    input  logic [3*COLOR_BITS-1:0]                       rdata1,
    output logic [$clog2(HALF_ROWS)+$clog2(NUM_COLS)-1:0] rd_addr,
    output logic                                          r1,
    output logic                                          g1,
    output logic                                          b1,
    output logic                                          r2,
    output logic                                          g2,
    output logic                                          b2,
    output logic                                          pclk,
    output logic                                          lat,
    output logic                                          oe_n,
    output logic [$clog2(HALF_ROWS)-1:0]                  row_sel,
    output logic                                          frame_start
);
    localparam int COL_W  = $clog2(NUM_COLS);
    localparam int ROW_W  = $clog2(HALF_ROWS);
    localparam int PL_W   = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int DW     = 3 * COLOR_BITS;
    localparam int TICK_W = $clog2(BASE_TICKS << (COLOR_BITS - 1)) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH, ST_DISPLAY} state_t;

    state_t                   st_q, st_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [PL_W-1:0]          plane_q, plane_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [1:0]               phase_q, phase_d;
    logic [TICK_W-1:0]        tick_q, tick_d;
    logic [ROW_W+COL_W-1:0]   rd_addr_q, rd_addr_d;
    logic [5:0]               rgb_q, rgb_d;          // {r1,g1,b1,r2,g2,b2}
    logic                     pclk_q, pclk_d;
    logic                     lat_q, lat_d;
    logic                     oe_n_q, oe_n_d;
    logic [ROW_W-1:0]         row_sel_q, row_sel_d;
    logic                     fs_q, fs_d;

    logic [DW-1:0]            d0, d1;
    logic [5:0]               plane_bits;
    logic [TICK_W-1:0]        disp_last;
    logic                     last_plane, last_row;

`ifdef GAMMA_EN
    localparam logic [3:0] GAMMA_LUT [16] = '{
        4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2,
        4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd10, 4'd12, 4'd15
    };
`endif

    // Channel data as seen by the plane selector (gamma-corrected if enabled).
    always_comb begin
        d0 = rdata0;
        d1 = rdata1;
`ifdef GAMMA_EN
        for (int c = 0; c < 3; c++) begin
            d0[c*COLOR_BITS +: COLOR_BITS] = GAMMA_LUT[rdata0[c*COLOR_BITS +: COLOR_BITS]];
            d1[c*COLOR_BITS +: COLOR_BITS] = GAMMA_LUT[rdata1[c*COLOR_BITS +: COLOR_BITS]];
        end
`endif
    end

    // Pick bit <plane> of each channel: R = d[2*CB+p], G = d[CB+p], B = d[p].
    always_comb begin
        plane_bits = '0;
        for (int p = 0; p < COLOR_BITS; p++) begin
            if (plane_q == PL_W'(p)) begin
                plane_bits = {d0[2*COLOR_BITS+p], d0[COLOR_BITS+p], d0[p],
                              d1[2*COLOR_BITS+p], d1[COLOR_BITS+p], d1[p]};
            end
        end
    end

    assign disp_last  = (TICK_W'(BASE_TICKS) << plane_q) - TICK_W'(1);
    assign last_plane = (plane_q == PL_W'(COLOR_BITS - 1));
    assign last_row   = (row_q == ROW_W'(HALF_ROWS - 1));

    always_comb begin
        st_d      = st_q;
        row_d     = row_q;
        plane_d   = plane_q;
        col_d     = col_q;
        phase_d   = phase_q;
        tick_d    = tick_q;
        rd_addr_d = rd_addr_q;
        rgb_d     = rgb_q;
        pclk_d    = pclk_q;
        lat_d     = 1'b0;
        oe_n_d    = 1'b1;
        row_sel_d = row_sel_q;
        fs_d      = 1'b0;

        case (st_q)
            ST_IDLE: begin
                rgb_d  = '0;
                pclk_d = 1'b0;
                if (enable) begin
                    st_d    = ST_SHIFT;
                    row_d   = '0;
                    plane_d = '0;
                    col_d   = '0;
                    phase_d = '0;
                    fs_d    = 1'b1;
                end
            end

            ST_SHIFT: begin
                phase_d = phase_q + 2'd1;
                case (phase_q)
                    2'd0: begin
                        rd_addr_d = {row_q, col_q};
                        pclk_d    = 1'b0;
                    end
                    2'd1: pclk_d = 1'b0;          // memory access cycle
                    2'd2: rgb_d  = plane_bits;    // data settles a cycle before pclk rises
                    default: begin
                        pclk_d = 1'b1;
                        col_d  = col_q + COL_W'(1);
                        if (col_q == COL_W'(NUM_COLS - 1)) begin
                            st_d  = ST_LATCH;
                            col_d = '0;
                        end
                    end
                endcase
            end

            ST_LATCH: begin
                pclk_d    = 1'b0;
                lat_d     = 1'b1;
                row_sel_d = row_q;
                tick_d    = '0;
                st_d      = ST_DISPLAY;
            end

            default: begin
                // oe_n is driven low on every display edge, so the registered
                // output is low for exactly BASE_TICKS<<plane cycles; the last
                // of them overlaps the first cycle of the following state.
                oe_n_d = 1'b0;
                tick_d = tick_q + TICK_W'(1);
                if (tick_q == disp_last) begin
                    if (last_plane) begin
                        plane_d = '0;
                        row_d   = last_row ? '0 : row_q + ROW_W'(1);
                    end else begin
                        plane_d = plane_q + PL_W'(1);
                    end
                    if (enable) begin
                        st_d    = ST_SHIFT;
                        phase_d = '0;
                        col_d   = '0;
                        fs_d    = last_plane && last_row;   // wrapping to row 0, plane 0
                    end else begin
                        st_d  = ST_IDLE;
                        rgb_d = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= ST_IDLE;
            row_q     <= '0;
            plane_q   <= '0;
            col_q     <= '0;
            phase_q   <= '0;
            tick_q    <= '0;
            rd_addr_q <= '0;
            rgb_q     <= '0;
            pclk_q    <= 1'b0;
            lat_q     <= 1'b0;
            oe_n_q    <= 1'b1;
            row_sel_q <= '0;
            fs_q      <= 1'b0;
        end else begin
            st_q      <= st_d;
            row_q     <= row_d;
            plane_q   <= plane_d;
            col_q     <= col_d;
            phase_q   <= phase_d;
            tick_q    <= tick_d;
            rd_addr_q <= rd_addr_d;
            rgb_q     <= rgb_d;
            pclk_q    <= pclk_d;
            lat_q     <= lat_d;
            oe_n_q    <= oe_n_d;
            row_sel_q <= row_sel_d;
            fs_q      <= fs_d;
        end
    end

    assign rd_addr                  = rd_addr_q;
    assign {r1, g1, b1, r2, g2, b2} = rgb_q;
    assign pclk                     = pclk_q;
    assign lat                      = lat_q;
    assign oe_n                     = oe_n_q;
    assign row_sel                  = row_sel_q;
    assign frame_start              = fs_q;

endmodule

// File: tb/tb_led_panel_scan.sv
// Testbench for led_panel_scan with BASE_TICKS=4. Random framebuffer contents,
// a behavioural scan model (row-plane index, pixel lookup, expected run lengths)
// and an event monitor sampling on the falling clock edge.
module tb_led_panel_scan;
    localparam int BT    = 4;
    localparam int FRAME = 32 * (4 * (256 + 1) + 15 * BT);   // 34816
`ifdef GAMMA_EN
    localparam logic [3:0] G197 = 4'b0101;   // gamma(4'hA) = 5
`else
    localparam logic [3:0] G197 = 4'b1010;   // raw 4'hA
`endif

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [11:0] rdata0 = '0, rdata1 = '0;
    logic [10:0] rd_addr;
    logic        r1, g1, b1, r2, g2, b2, pclk, lat, oe_n, frame_start;
    logic [4:0]  row_sel;

    always #5 clk = ~clk;

    led_panel_scan #(.BASE_TICKS(BT)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .rdata0(rdata0), .rdata1(rdata1), .rd_addr(rd_addr),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
        .pclk(pclk), .lat(lat), .oe_n(oe_n), .row_sel(row_sel),
        .frame_start(frame_start)
    );

    // Framebuffer halves: synchronous read, data one cycle after the address.
    logic [11:0] mem0 [2048];
    logic [11:0] mem1 [2048];
    always @(posedge clk) begin
        rdata0 <= mem0[rd_addr];
        rdata1 <= mem1[rd_addr];
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] gam(input logic [3:0] v);
`ifdef GAMMA_EN
        case (v)
            4'd0, 4'd1, 4'd2:   return 4'd0;
            4'd3, 4'd4, 4'd5:   return 4'd1;
            4'd6, 4'd7:         return 4'd2;
            4'd8:               return 4'd3;
            4'd9:               return 4'd4;
            4'd10:              return 4'd5;
            4'd11:              return 4'd6;
            4'd12:              return 4'd8;
            4'd13:              return 4'd10;
            4'd14:              return 4'd12;
            default:            return 4'd15;
        endcase
`else
        return v;
`endif
    endfunction

    // Expected {r1,g1,b1,r2,g2,b2} for a pixel column in a given row-plane.
    function automatic logic [5:0] exp_pix(input logic [4:0] row, input logic [5:0] col,
                                           input logic [1:0] pl);
        logic [11:0] a, b;
        logic [3:0]  ar, ag, ab, br, bg, bb;
        a  = mem0[{row, col}];
        b  = mem1[{row, col}];
        ar = gam(a[11:8]); ag = gam(a[7:4]); ab = gam(a[3:0]);
        br = gam(b[11:8]); bg = gam(b[7:4]); bb = gam(b[3:0]);
        return {ar[pl], ag[pl], ab[pl], br[pl], bg[pl], bb[pl]};
    endfunction

    // Scan model: idx = row*4 + plane of the row-plane being shifted/displayed.
    int         cyc = 0, idx = 0, pcnt = 0, olen = 0, fs_cyc = 0, fs_count = 0;
    bit         mon_en = 0, fs_seen = 0, fs_valid = 0, seed197 = 0;
    logic       prev_pclk = 0, prev_oe = 1, prev_lat = 0;
    logic [4:0] m_row;
    logic [1:0] m_pl;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (mon_en) begin
            m_row = 5'(idx / 4);
            m_pl  = 2'(idx % 4);
            if (frame_start) begin
                if (fs_valid) chk("frame_period", cyc - fs_cyc, FRAME);
                fs_cyc   = cyc;
                fs_valid = 1;
                fs_seen  = 1;
                fs_count++;
            end
            if (pclk && !prev_pclk) begin
                chk("rd_addr", rd_addr, {m_row, 6'(pcnt)});
                chk("pix", {r1, g1, b1, r2, g2, b2}, exp_pix(m_row, 6'(pcnt), m_pl));
                if (seed197 && m_row == 5'd3 && pcnt == 5) chk("g1_x5y3", g1, G197[m_pl]);
                pcnt++;
            end
            if (lat) begin
                chk("lat_width", prev_lat, 0);
                chk("pclk_count", pcnt, 64);
                chk("row_sel", row_sel, m_row);
                chk("oe_n_at_lat", oe_n, 1);
                chk("fs_at_row_plane", fs_seen, idx == 0);
                // 256 shift cycles plus the latch cycle, then lat shows on the register
                if (fs_seen) chk("lat_delay", cyc - fs_cyc, 257);
                fs_seen = 0;
                pcnt    = 0;
            end
            if (!oe_n) olen++;
            else if (!prev_oe) begin
                chk("oe_len", olen, BT << m_pl);
                olen = 0;
                idx  = (idx + 1) % 128;
            end
        end
        prev_pclk = pclk;
        prev_oe   = oe_n;
        prev_lat  = lat;
    end

    task automatic check_reset_outs(input string tag);
        chk({tag, "_oe_n"}, oe_n, 1);
        chk({tag, "_pclk"}, pclk, 0);
        chk({tag, "_lat"}, lat, 0);
        chk({tag, "_fs"}, frame_start, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_row_sel"}, row_sel, 0);
        chk({tag, "_rgb"}, {r1, g1, b1, r2, g2, b2}, 0);
    endtask

    task automatic model_restart();
        idx = 0; pcnt = 0; olen = 0;
        fs_seen = 0; fs_valid = 0;
    endtask

    initial begin
        int fs_before, idx_before;
        for (int i = 0; i < 2048; i++) begin
            mem0[i] = 12'($urandom);
            mem1[i] = 12'($urandom);
        end
        mem0[197] = 12'h0A0;
        mem0[5]   = 12'h800;   // R=8 at row 0 col 5
        seed197   = 1;

        reset = 1; enable = 0;
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        reset = 0;
        repeat (5) @(negedge clk);
        chk("idle_no_pclk", pclk, 0);

        // Start a continuous run.
        model_restart();
        mon_en = 1;
        enable = 1;
        @(negedge clk);
        chk("first_fs", frame_start, 1);
        chk("first_oe_n", oe_n, 1);
        @(negedge clk);
        chk("first_rd_addr", rd_addr, 0);

        // One full frame, into the next one (covers row wrap and frame period).
        for (int i = 0; i < FRAME + 2000 && fs_count < 2; i++) @(negedge clk);
        chk("wait_frame2", fs_count >= 2, 1);
        for (int i = 0; i < 200 && pcnt < 10; i++) @(negedge clk);
        chk("wait_col10", pcnt >= 10, 1);

        // Drop enable mid-shift: current row-plane completes, then IDLE.
        idx_before = idx;
        enable = 0;
        for (int i = 0; i < 2000 && idx == idx_before; i++) @(negedge clk);
        chk("drop_completes", idx, (idx_before + 1) % 128);
        repeat (4) @(negedge clk);
        fs_before = fs_count;
        chk("idle_oe_n", oe_n, 1);
        chk("idle_pclk", pclk, 0);
        chk("idle_lat", lat, 0);
        chk("idle_rgb", {r1, g1, b1, r2, g2, b2}, 0);
        repeat (300) @(negedge clk);
        chk("idle_no_shift", pcnt, 0);
        chk("idle_no_fs", fs_count, fs_before);

        // Restart with solid colours: must begin again at row 0, plane 0.
        seed197 = 0;
        for (int i = 0; i < 2048; i++) begin
            mem0[i] = 12'hF00;
            mem1[i] = 12'h00F;
        end
        model_restart();
        enable = 1;
        @(negedge clk);
        chk("restart_fs", frame_start, 1);
        chk("restart_oe_n", oe_n, 1);
        for (int i = 0; i < 3000 && idx < 6; i++) @(negedge clk);
        chk("wait_restart_planes", idx >= 6, 1);

        // Reset during a display slot blanks the panel on the next edge.
        for (int i = 0; i < 600 && oe_n; i++) @(negedge clk);
        chk("wait_display", oe_n, 0);
        mon_en = 0;
        reset  = 1;
        @(negedge clk);
        check_reset_outs("mid_rst");
        reset  = 0;
        enable = 0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
